// File: rtl/ram_protocol_checker_if.sv
// Command/response bus between a RAM and its command source, observed by the protocol checker.
// The master side drives everything; the checker only ever listens through the slave modport.
interface ram_protocol_checker_if #(
    parameter int ADDR_SIZE = 8
);
    logic [ADDR_SIZE+1:0] din;
    logic                 rx_valid;
    logic [ADDR_SIZE-1:0] dout;
    logic                 tx_valid;

    modport master (
        output din,
        output rx_valid,
        output dout,
        output tx_valid
    );

    modport slave (
        input din,
        input rx_valid,
        input dout,
        input tx_valid
    );
endinterface

// File: rtl/ram_protocol_checker.sv
// Passive checker for a command-driven RAM: keeps a shadow copy of written data and verifies
// read responses for timing and content, raising sticky error flags and event counters.
module ram_protocol_checker #(
    parameter int ADDR_SIZE  = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int TX_LATENCY = 1,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_protocol_checker_if.slave bus,
    output logic                 err_reset,
    output logic                 err_latency,
    output logic                 err_data,
    output logic                 err_seq,
    output logic                 err_spurious,
    output logic                 err_any,
    output logic [CNT_W-1:0]     write_cnt,
    output logic [CNT_W-1:0]     read_cnt,
    output logic [CNT_W-1:0]     unk_cnt,
    output logic [CNT_W-1:0]     err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK
    } state_e;

    localparam logic [2:0]         LAT_LOAD  = 3'(TX_LATENCY - 1);
    localparam logic [ADDR_SIZE:0] DEPTH_LIM = (ADDR_SIZE+1)'(MEM_DEPTH);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    logic [1:0]           opcode;
    logic [ADDR_SIZE-1:0] payload;
    logic                 in_range;
    logic                 is_wa, is_wd, is_ra, is_rd;

    assign opcode   = bus.din[ADDR_SIZE+1:ADDR_SIZE];
    assign payload  = bus.din[ADDR_SIZE-1:0];
    assign in_range = {1'b0, payload} < DEPTH_LIM;
    assign is_wa    = bus.rx_valid && (opcode == 2'b00);
    assign is_wd    = bus.rx_valid && (opcode == 2'b01);
    assign is_ra    = bus.rx_valid && (opcode == 2'b10);
    assign is_rd    = bus.rx_valid && (opcode == 2'b11);

    state_e               state_q, state_d;
    logic [2:0]           lat_cnt_q, lat_cnt_d;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic                 wr_addr_vld_q, wr_addr_vld_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic                 rd_addr_vld_q, rd_addr_vld_d;
    logic [ADDR_SIZE-1:0] expected_q, expected_d;
    logic                 exp_known_q, exp_known_d;
    logic [MEM_DEPTH-1:0] known_q;
    logic [ADDR_SIZE-1:0] shadow_q [MEM_DEPTH];
    logic                 rst_prev_q;
    logic [4:0]           flags_q;
    logic [CNT_W-1:0]     write_cnt_q, read_cnt_q, unk_cnt_q, err_cnt_q;

    logic ev_reset, ev_latency, ev_data, ev_seq, ev_spur;
    logic do_write, inc_read, inc_unk;
    logic [4:0] ev_vec;

    always_comb begin
        state_d       = state_q;
        lat_cnt_d     = lat_cnt_q;
        wr_addr_d     = wr_addr_q;
        wr_addr_vld_d = wr_addr_vld_q;
        rd_addr_d     = rd_addr_q;
        rd_addr_vld_d = rd_addr_vld_q;
        expected_d    = expected_q;
        exp_known_d   = exp_known_q;
        ev_latency    = 1'b0;
        ev_data       = 1'b0;
        ev_seq        = 1'b0;
        ev_spur       = 1'b0;
        do_write      = 1'b0;
        inc_read      = 1'b0;
        inc_unk       = 1'b0;

        // The RAM must come out of reset quiet; anything else is reported once.
        ev_reset = rst_prev_q && ((bus.dout != '0) || bus.tx_valid);

        if (is_wa) begin
            if (in_range) begin
                wr_addr_d     = payload;
                wr_addr_vld_d = 1'b1;
            end else begin
                ev_seq = 1'b1;
            end
        end

        if (is_wd) begin
            if (wr_addr_vld_q) do_write = 1'b1;
            else               ev_seq   = 1'b1;
        end

        if (is_ra) begin
            if (in_range) begin
                rd_addr_d     = payload;
                rd_addr_vld_d = 1'b1;
            end else begin
                ev_seq = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.tx_valid) ev_spur = 1'b1;
                if (is_rd) begin
                    if (rd_addr_vld_q) begin
                        lat_cnt_d   = LAT_LOAD;
                        expected_d  = shadow_q[rd_addr_q];
                        exp_known_d = known_q[rd_addr_q];
                        state_d     = (TX_LATENCY == 1) ? S_CHECK : S_WAIT;
                    end else begin
                        ev_seq = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (bus.tx_valid) ev_latency = 1'b1;
                if (is_rd)        ev_seq     = 1'b1;
                lat_cnt_d = lat_cnt_q - 3'd1;
                if (lat_cnt_q == 3'd1) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (!bus.tx_valid) ev_latency = 1'b1;
                else if (exp_known_q && (bus.dout != expected_q)) ev_data = 1'b1;
                if (!exp_known_q) inc_unk = 1'b1;
                if (is_rd)        ev_seq  = 1'b1;
                inc_read = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ev_vec = {ev_reset, ev_latency, ev_data, ev_seq, ev_spur};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            lat_cnt_q     <= '0;
            wr_addr_q     <= '0;
            wr_addr_vld_q <= 1'b0;
            rd_addr_q     <= '0;
            rd_addr_vld_q <= 1'b0;
            expected_q    <= '0;
            exp_known_q   <= 1'b0;
            known_q       <= '0;
            rst_prev_q    <= 1'b1;
            flags_q       <= '0;
            write_cnt_q   <= '0;
            read_cnt_q    <= '0;
            unk_cnt_q     <= '0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            lat_cnt_q     <= lat_cnt_d;
            wr_addr_q     <= wr_addr_d;
            wr_addr_vld_q <= wr_addr_vld_d;
            rd_addr_q     <= rd_addr_d;
            rd_addr_vld_q <= rd_addr_vld_d;
            expected_q    <= expected_d;
            exp_known_q   <= exp_known_d;
            rst_prev_q    <= 1'b0;
            if (do_write) known_q[wr_addr_q] <= 1'b1;
            flags_q       <= flags_q | ev_vec;
            write_cnt_q   <= sat_inc(write_cnt_q, do_write);
            read_cnt_q    <= sat_inc(read_cnt_q, inc_read);
            unk_cnt_q     <= sat_inc(unk_cnt_q, inc_unk);
            err_cnt_q     <= sat_inc(err_cnt_q, |ev_vec);
        end
    end

    // Shadow data needs no reset: the known bits decide whether it is trusted.
    always_ff @(posedge clk) begin
        if (!rst && do_write) shadow_q[wr_addr_q] <= payload;
    end

    assign err_reset    = flags_q[4];
    assign err_latency  = flags_q[3];
    assign err_data     = flags_q[2];
    assign err_seq      = flags_q[1];
    assign err_spurious = flags_q[0];
    assign err_any      = |flags_q;
    assign write_cnt    = write_cnt_q;
    assign read_cnt     = read_cnt_q;
    assign unk_cnt      = unk_cnt_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_ram_protocol_checker.sv
// Directed bench: three checkers share one bus (default, latency-3 with 128-entry shadow,
// and 2-bit counters) so each scenario can be judged against the instance it targets.
module tb_ram_protocol_checker;

    logic clk;
    logic rst;
    int   testCount = 0;
    int   failCount = 0;

    ram_protocol_checker_if #(.ADDR_SIZE(8)) bus ();

    logic        d1ErrReset, d1ErrLatency, d1ErrData, d1ErrSeq, d1ErrSpurious, d1ErrAny;
    logic [15:0] d1WriteCnt, d1ReadCnt, d1UnkCnt, d1ErrCnt;
    logic        d3ErrReset, d3ErrLatency, d3ErrData, d3ErrSeq, d3ErrSpurious, d3ErrAny;
    logic [15:0] d3WriteCnt, d3ReadCnt, d3UnkCnt, d3ErrCnt;
    logic        sErrReset, sErrLatency, sErrData, sErrSeq, sErrSpurious, sErrAny;
    logic [1:0]  sWriteCnt, sReadCnt, sUnkCnt, sErrCnt;

    ram_protocol_checker dut1 (
        .clk(clk), .rst(rst), .bus(bus),
        .err_reset(d1ErrReset), .err_latency(d1ErrLatency), .err_data(d1ErrData),
        .err_seq(d1ErrSeq), .err_spurious(d1ErrSpurious), .err_any(d1ErrAny),
        .write_cnt(d1WriteCnt), .read_cnt(d1ReadCnt), .unk_cnt(d1UnkCnt), .err_cnt(d1ErrCnt)
    );

    ram_protocol_checker #(.MEM_DEPTH(128), .TX_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus),
        .err_reset(d3ErrReset), .err_latency(d3ErrLatency), .err_data(d3ErrData),
        .err_seq(d3ErrSeq), .err_spurious(d3ErrSpurious), .err_any(d3ErrAny),
        .write_cnt(d3WriteCnt), .read_cnt(d3ReadCnt), .unk_cnt(d3UnkCnt), .err_cnt(d3ErrCnt)
    );

    ram_protocol_checker #(.CNT_W(2)) dutSat (
        .clk(clk), .rst(rst), .bus(bus),
        .err_reset(sErrReset), .err_latency(sErrLatency), .err_data(sErrData),
        .err_seq(sErrSeq), .err_spurious(sErrSpurious), .err_any(sErrAny),
        .write_cnt(sWriteCnt), .read_cnt(sReadCnt), .unk_cnt(sUnkCnt), .err_cnt(sErrCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] payload);
        bus.din      = {op, payload};
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        bus.din      = '0;
    endtask

    task automatic respond(input logic [7:0] data);
        bus.tx_valid = 1'b1;
        bus.dout     = data;
        tick();
        bus.tx_valid = 1'b0;
        bus.dout     = '0;
    endtask

    task automatic doReset();
        bus.din = '0; bus.rx_valid = 1'b0; bus.dout = '0; bus.tx_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        doReset();
        if (d1ErrAny !== 1'b0) begin $display("[TB] FAIL reset_err_any: got %0b expected 0", d1ErrAny); failCount++; end
        testCount++;
        if ({d1ErrReset, d1ErrLatency, d1ErrData, d1ErrSeq, d1ErrSpurious} !== 5'b0) begin $display("[TB] FAIL reset_flags: got %b expected 00000", {d1ErrReset, d1ErrLatency, d1ErrData, d1ErrSeq, d1ErrSpurious}); failCount++; end
        testCount++;
        if (d1WriteCnt !== 16'd0) begin $display("[TB] FAIL reset_write_cnt: got %0d expected 0", d1WriteCnt); failCount++; end
        testCount++;
        if (d1ReadCnt !== 16'd0) begin $display("[TB] FAIL reset_read_cnt: got %0d expected 0", d1ReadCnt); failCount++; end
        testCount++;
        if (d1UnkCnt !== 16'd0) begin $display("[TB] FAIL reset_unk_cnt: got %0d expected 0", d1UnkCnt); failCount++; end
        testCount++;
        if (d1ErrCnt !== 16'd0) begin $display("[TB] FAIL reset_err_cnt: got %0d expected 0", d1ErrCnt); failCount++; end
        testCount++;
    endtask

    task automatic test_write_read_ok();
        doReset();
        applyStimulus(2'b00, 8'h12);
        applyStimulus(2'b01, 8'hAB);
        applyStimulus(2'b10, 8'h12);
        applyStimulus(2'b11, 8'h00);
        respond(8'hAB);
        if (d1ErrAny !== 1'b0) begin $display("[TB] FAIL ok_err_any: got %0b expected 0", d1ErrAny); failCount++; end
        testCount++;
        if (d1WriteCnt !== 16'd1) begin $display("[TB] FAIL ok_write_cnt: got %0d expected 1", d1WriteCnt); failCount++; end
        testCount++;
        if (d1ReadCnt !== 16'd1) begin $display("[TB] FAIL ok_read_cnt: got %0d expected 1", d1ReadCnt); failCount++; end
        testCount++;
        if (d1ErrCnt !== 16'd0) begin $display("[TB] FAIL ok_err_cnt: got %0d expected 0", d1ErrCnt); failCount++; end
        testCount++;
    endtask

    task automatic test_data_mismatch();
        doReset();
        applyStimulus(2'b00, 8'h12);
        applyStimulus(2'b01, 8'hAB);
        applyStimulus(2'b10, 8'h12);
        applyStimulus(2'b11, 8'h00);
        respond(8'hAC);
        if (d1ErrData !== 1'b1) begin $display("[TB] FAIL mism_err_data: got %0b expected 1", d1ErrData); failCount++; end
        testCount++;
        if (d1ErrAny !== 1'b1) begin $display("[TB] FAIL mism_err_any: got %0b expected 1", d1ErrAny); failCount++; end
        testCount++;
        if (d1ErrCnt !== 16'd1) begin $display("[TB] FAIL mism_err_cnt: got %0d expected 1", d1ErrCnt); failCount++; end
        testCount++;
        if (d1ErrLatency !== 1'b0) begin $display("[TB] FAIL mism_err_latency: got %0b expected 0", d1ErrLatency); failCount++; end
        testCount++;
    endtask

    task automatic test_latency();
        doReset();
        applyStimulus(2'b00, 8'h12);
        applyStimulus(2'b01, 8'h55);
        applyStimulus(2'b10, 8'h12);
        applyStimulus(2'b11, 8'h00);
        tick();
        tick();
        respond(8'h55);
        if (d3ErrAny !== 1'b0) begin $display("[TB] FAIL lat_ontime_err_any: got %0b expected 0", d3ErrAny); failCount++; end
        testCount++;
        if (d3ReadCnt !== 16'd1) begin $display("[TB] FAIL lat_ontime_read_cnt: got %0d expected 1", d3ReadCnt); failCount++; end
        testCount++;
        applyStimulus(2'b11, 8'h00);
        tick();
        respond(8'h55);
        if (d3ErrLatency !== 1'b1) begin $display("[TB] FAIL lat_early_flag: got %0b expected 1", d3ErrLatency); failCount++; end
        testCount++;
        if (d3ErrCnt !== 16'd1) begin $display("[TB] FAIL lat_early_err_cnt: got %0d expected 1", d3ErrCnt); failCount++; end
        testCount++;
        tick();
        if (d3ErrCnt !== 16'd2) begin $display("[TB] FAIL lat_absent_err_cnt: got %0d expected 2", d3ErrCnt); failCount++; end
        testCount++;
        if (d3ReadCnt !== 16'd2) begin $display("[TB] FAIL lat_absent_read_cnt: got %0d expected 2", d3ReadCnt); failCount++; end
        testCount++;
        if (d3ErrData !== 1'b0) begin $display("[TB] FAIL lat_err_data: got %0b expected 0", d3ErrData); failCount++; end
        testCount++;
    endtask

    task automatic test_seq();
        doReset();
        applyStimulus(2'b01, 8'h77);
        if (d1ErrSeq !== 1'b1) begin $display("[TB] FAIL seq_nowa_flag: got %0b expected 1", d1ErrSeq); failCount++; end
        testCount++;
        if (d1WriteCnt !== 16'd0) begin $display("[TB] FAIL seq_nowa_write_cnt: got %0d expected 0", d1WriteCnt); failCount++; end
        testCount++;
        applyStimulus(2'b10, 8'h00);
        applyStimulus(2'b11, 8'h00);
        respond(8'h77);
        if (d1UnkCnt !== 16'd1) begin $display("[TB] FAIL seq_shadow_unk_cnt: got %0d expected 1", d1UnkCnt); failCount++; end
        testCount++;
        if (d1ErrData !== 1'b0) begin $display("[TB] FAIL seq_shadow_err_data: got %0b expected 0", d1ErrData); failCount++; end
        testCount++;
        if (d1ErrCnt !== 16'd1) begin $display("[TB] FAIL seq_shadow_err_cnt: got %0d expected 1", d1ErrCnt); failCount++; end
        testCount++;

        doReset();
        applyStimulus(2'b00, 8'h20);
        applyStimulus(2'b01, 8'h3C);
        applyStimulus(2'b10, 8'h20);
        applyStimulus(2'b11, 8'h00);
        applyStimulus(2'b11, 8'h00);
        applyStimulus(2'b01, 8'h99);
        respond(8'h3C);
        if (d3ErrSeq !== 1'b1) begin $display("[TB] FAIL seq_dup_flag: got %0b expected 1", d3ErrSeq); failCount++; end
        testCount++;
        if (d3ErrData !== 1'b0) begin $display("[TB] FAIL seq_dup_err_data: got %0b expected 0", d3ErrData); failCount++; end
        testCount++;
        if (d3ErrLatency !== 1'b0) begin $display("[TB] FAIL seq_dup_err_latency: got %0b expected 0", d3ErrLatency); failCount++; end
        testCount++;
        if (d3ReadCnt !== 16'd1) begin $display("[TB] FAIL seq_dup_read_cnt: got %0d expected 1", d3ReadCnt); failCount++; end
        testCount++;
        if (d3WriteCnt !== 16'd2) begin $display("[TB] FAIL seq_dup_write_cnt: got %0d expected 2", d3WriteCnt); failCount++; end
        testCount++;
        if (d3ErrCnt !== 16'd1) begin $display("[TB] FAIL seq_dup_err_cnt: got %0d expected 1", d3ErrCnt); failCount++; end
        testCount++;
    endtask

    task automatic test_out_of_range();
        doReset();
        applyStimulus(2'b00, 8'h80);
        if (d3ErrSeq !== 1'b1) begin $display("[TB] FAIL oor_wa_flag: got %0b expected 1", d3ErrSeq); failCount++; end
        testCount++;
        applyStimulus(2'b01, 8'h11);
        if (d3ErrCnt !== 16'd2) begin $display("[TB] FAIL oor_wd_err_cnt: got %0d expected 2", d3ErrCnt); failCount++; end
        testCount++;
        if (d3WriteCnt !== 16'd0) begin $display("[TB] FAIL oor_wd_write_cnt: got %0d expected 0", d3WriteCnt); failCount++; end
        testCount++;
        applyStimulus(2'b00, 8'h7F);
        applyStimulus(2'b01, 8'h22);
        if (d3WriteCnt !== 16'd1) begin $display("[TB] FAIL oor_edge_write_cnt: got %0d expected 1", d3WriteCnt); failCount++; end
        testCount++;
        applyStimulus(2'b10, 8'h7F);
        applyStimulus(2'b10, 8'h90);
        if (d3ErrCnt !== 16'd3) begin $display("[TB] FAIL oor_ra_err_cnt: got %0d expected 3", d3ErrCnt); failCount++; end
        testCount++;
        applyStimulus(2'b11, 8'h00);
        tick();
        tick();
        respond(8'h22);
        if (d3ErrData !== 1'b0) begin $display("[TB] FAIL oor_read_err_data: got %0b expected 0", d3ErrData); failCount++; end
        testCount++;
        if (d3UnkCnt !== 16'd0) begin $display("[TB] FAIL oor_read_unk_cnt: got %0d expected 0", d3UnkCnt); failCount++; end
        testCount++;
        if (d3ReadCnt !== 16'd1) begin $display("[TB] FAIL oor_read_read_cnt: got %0d expected 1", d3ReadCnt); failCount++; end
        testCount++;
    endtask

    task automatic test_unknown_spurious();
        doReset();
        applyStimulus(2'b10, 8'h40);
        applyStimulus(2'b11, 8'h00);
        respond(8'h5A);
        if (d1UnkCnt !== 16'd1) begin $display("[TB] FAIL unk_unk_cnt: got %0d expected 1", d1UnkCnt); failCount++; end
        testCount++;
        if (d1ErrData !== 1'b0) begin $display("[TB] FAIL unk_err_data: got %0b expected 0", d1ErrData); failCount++; end
        testCount++;
        if (d1ReadCnt !== 16'd1) begin $display("[TB] FAIL unk_read_cnt: got %0d expected 1", d1ReadCnt); failCount++; end
        testCount++;
        respond(8'h00);
        if (d1ErrSpurious !== 1'b1) begin $display("[TB] FAIL spur_flag: got %0b expected 1", d1ErrSpurious); failCount++; end
        testCount++;
        if (d1ErrAny !== 1'b1) begin $display("[TB] FAIL spur_err_any: got %0b expected 1", d1ErrAny); failCount++; end
        testCount++;
        if (d1ErrCnt !== 16'd1) begin $display("[TB] FAIL spur_err_cnt: got %0d expected 1", d1ErrCnt); failCount++; end
        testCount++;
    endtask

    task automatic test_back_to_back();
        doReset();
        applyStimulus(2'b00, 8'h01);
        for (int i = 0; i < 5; i++) applyStimulus(2'b01, 8'(i));
        if (d1WriteCnt !== 16'd5) begin $display("[TB] FAIL b2b_write_cnt: got %0d expected 5", d1WriteCnt); failCount++; end
        testCount++;
        if (sWriteCnt !== 2'd3) begin $display("[TB] FAIL b2b_sat_write_cnt: got %0d expected 3", sWriteCnt); failCount++; end
        testCount++;
        applyStimulus(2'b10, 8'h01);
        applyStimulus(2'b11, 8'h00);
        respond(8'h04);
        if (d1ErrAny !== 1'b0) begin $display("[TB] FAIL b2b_read_err_any: got %0b expected 0", d1ErrAny); failCount++; end
        testCount++;
        if (d1ReadCnt !== 16'd1) begin $display("[TB] FAIL b2b_read_cnt: got %0d expected 1", d1ReadCnt); failCount++; end
        testCount++;
        for (int i = 0; i < 4; i++) respond(8'h00);
        if (d1ErrCnt !== 16'd4) begin $display("[TB] FAIL b2b_err_cnt: got %0d expected 4", d1ErrCnt); failCount++; end
        testCount++;
        if (sErrCnt !== 2'd3) begin $display("[TB] FAIL b2b_sat_err_cnt: got %0d expected 3", sErrCnt); failCount++; end
        testCount++;
    endtask

    task automatic test_reset_errors();
        bus.din = '0; bus.rx_valid = 1'b0; bus.dout = '0; bus.tx_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.dout = 8'h01;
        tick();
        bus.dout = 8'h00;
        if (d1ErrReset !== 1'b1) begin $display("[TB] FAIL rsterr_flag: got %0b expected 1", d1ErrReset); failCount++; end
        testCount++;
        if (d1ErrCnt !== 16'd1) begin $display("[TB] FAIL rsterr_err_cnt: got %0d expected 1", d1ErrCnt); failCount++; end
        testCount++;
        if (d1ErrSpurious !== 1'b0) begin $display("[TB] FAIL rsterr_spurious: got %0b expected 0", d1ErrSpurious); failCount++; end
        testCount++;

        doReset();
        applyStimulus(2'b00, 8'h10);
        applyStimulus(2'b01, 8'h42);
        applyStimulus(2'b10, 8'h10);
        applyStimulus(2'b11, 8'h00);
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        if (d3ErrLatency !== 1'b0) begin $display("[TB] FAIL midrst_err_latency: got %0b expected 0", d3ErrLatency); failCount++; end
        testCount++;
        if (d3ErrAny !== 1'b0) begin $display("[TB] FAIL midrst_err_any: got %0b expected 0", d3ErrAny); failCount++; end
        testCount++;
        if ({d3WriteCnt, d3ReadCnt, d3UnkCnt, d3ErrCnt} !== 64'd0) begin $display("[TB] FAIL midrst_counters: got %h expected 0", {d3WriteCnt, d3ReadCnt, d3UnkCnt, d3ErrCnt}); failCount++; end
        testCount++;
        if (d1ErrReset !== 1'b0) begin $display("[TB] FAIL midrst_err_reset_cleared: got %0b expected 0", d1ErrReset); failCount++; end
        testCount++;
    endtask

    initial begin
        rst          = 1'b1;
        bus.din      = '0;
        bus.rx_valid = 1'b0;
        bus.dout     = '0;
        bus.tx_valid = 1'b0;
        test_reset();
        test_write_read_ok();
        test_data_mismatch();
        test_latency();
        test_seq();
        test_out_of_range();
        test_unknown_spurious();
        test_back_to_back();
        test_reset_errors();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/ram_protocol_checker.md
RAM_PROTOCOL_CHECKER -- requirements
Module: ram_protocol_checker

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 8, meaning the address and data width.
REQ-002 SHALL have parameter MEM_DEPTH, default 256, meaning the shadow memory depth (at most 2**ADDR_SIZE).
REQ-003 SHALL have parameter TX_LATENCY, default 1, range 1..7, meaning the cycles from a read-data command to tx_valid.
REQ-004 SHALL have parameter CNT_W, default 16, meaning the width of all counters.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset: synchronous and active-high.
REQ-007 SHALL have port din, input, ADDR_SIZE+2, the RAM command: [ADDR_SIZE+1:ADDR_SIZE] opcode, [ADDR_SIZE-1:0] payload.
REQ-008 SHALL have port rx_valid, input, 1, meaning din is valid this cycle.
REQ-009 SHALL have port dout, input, ADDR_SIZE, the RAM read data under observation.
REQ-010 SHALL have port tx_valid, input, 1, meaning the RAM is presenting dout.
REQ-011 SHALL have outputs err_reset, err_latency, err_data, err_seq, err_spurious, each 1 bit, sticky error flags.
REQ-012 SHALL have output err_any, 1 bit, the OR of all five error flags.
REQ-013 SHALL have outputs write_cnt, read_cnt, unk_cnt, err_cnt, each CNT_W bits.

Function
REQ-014 SHALL decode opcodes when rx_valid=1: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
REQ-015 SHALL, on 00, latch payload into wr_addr and set wr_addr_vld.
REQ-016 SHALL, on 01 with wr_addr_vld=1, store payload in shadow[wr_addr], set known[wr_addr], and increment write_cnt.
REQ-017 SHALL, on 10, latch payload into rd_addr and set rd_addr_vld.
REQ-018 SHALL, on 01 with wr_addr_vld=0 or on 11 with rd_addr_vld=0, set err_seq and make no shadow update or expectation.
REQ-019 SHALL, when an address is at least MEM_DEPTH, treat the command as out of range: set err_seq and ignore it.
REQ-020 SHALL run a read FSM with states IDLE, WAIT and CHECK.
REQ-021 SHALL, in IDLE on a valid 11: load down-counter=TX_LATENCY-1, capture expected=shadow[rd_addr] and exp_known=known[rd_addr], and enter WAIT (or CHECK directly if TX_LATENCY=1).
REQ-022 SHALL, in WAIT, decrement the counter each cycle and enter CHECK at 0; tx_valid=1 while in WAIT sets err_latency.
REQ-023 SHALL, in CHECK: tx_valid=0 sets err_latency; tx_valid=1 with exp_known and dout!=expected sets err_data; exp_known=0 increments unk_cnt with no data check; read_cnt increments; next state IDLE.
REQ-024 SHALL, on a new 11 while in WAIT or CHECK, set err_seq and ignore the new command; the pending check continues.
REQ-025 SHALL, on tx_valid=1 while in IDLE, set err_spurious.
REQ-026 SHALL, on write-data to rd_addr while a read is pending, keep the captured expected value unchanged.
REQ-027 SHALL keep error flags sticky until rst.
REQ-028 SHALL increment err_cnt by 1 in each cycle where at least one new error event occurs, including events on already-set flags.
REQ-029 SHALL saturate all counters at 2**CNT_W-1.
REQ-030 SHALL update all outputs as registers, one cycle after the causing event.

Reset
REQ-031 SHALL, while rst=1, clear all flags, counters, wr_addr_vld, rd_addr_vld and every known bit, and put the FSM in IDLE.
REQ-032 SHALL, in the first cycle after rst falls, set err_reset if dout!=0 or tx_valid!=0.
REQ-033 SHALL, on rst asserted mid-read, abandon the pending check with no error raised.

Verification
REQ-034 SHALL cover: write 00/0x12, 01/0xAB, read 10/0x12, 11/xx, DUT tx_valid after 1 cycle with dout=0xAB -> no errors, write_cnt=1, read_cnt=1.
REQ-035 SHALL cover: same sequence with dout=0xAC -> err_data=1, err_any=1, err_cnt=1.
REQ-036 SHALL cover: TX_LATENCY=3, tx_valid arrives at cycle 2 -> err_latency=1; tx_valid absent at cycle 3 -> err_latency=1.
REQ-037 SHALL cover: 01 after reset with no 00 -> err_seq=1 and shadow unchanged; a second 11 during WAIT -> err_seq=1 with the original check still performed.
REQ-038 SHALL cover: read of an unwritten address 0x40 -> unk_cnt=1 with no err_data; tx_valid in IDLE -> err_spurious=1.
REQ-039 SHALL cover: dout=0x01 in the cycle after rst deasserts -> err_reset=1; rst mid-WAIT -> all outputs 0 and no err_latency.
